// File: rtl/otp_pkg.sv
// Shared types and default sizes for the one-time-pad scheduler.
package otp_pkg;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    // Which requester received the most recent grant.
    typedef enum logic {
        GNT_ENC = 1'b0,
        GNT_DEC = 1'b1
    } gnt_e;

endpackage : otp_pkg

// File: rtl/otp_pad_store.sv
// Pad slot storage: DEPTH x W pads with per-slot valid bits, a write port,
// a combinational read port, an invalidate port and free-slot bookkeeping.
module otp_pad_store
    import otp_pkg::*;
#(
    parameter int unsigned W     = otp_pkg::W,
    parameter int unsigned DEPTH = otp_pkg::DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_slot,
    input  logic [W-1:0]  wr_data,
    input  logic          inv_en,
    input  logic [AW-1:0] inv_slot,
    input  logic [AW-1:0] rd_slot,
    output logic [W-1:0]  rd_data_c,
    output logic          rd_valid_c,
    output logic [AW-1:0] free_slot_c,
    output logic          full_c,
    output logic [AW:0]   free_count
);

    localparam int unsigned CW = AW + 1;

    logic [W-1:0]     pad_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    free_cnt_d;

    // Pad contents need no reset; a slot is only readable once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pad_q[wr_slot] <= wr_data;
        end
    end

    // Next valid vector: set on write, cleared on invalidate (never both in one cycle).
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_slot] = 1'b1;
        end
        if (inv_en) begin
            valid_d[inv_slot] = 1'b0;
        end
    end

    // Popcount of free slots in the next vector so free_count tracks valid_q exactly.
    always_comb begin
        free_cnt_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            free_cnt_d = free_cnt_d + CW'(!valid_d[i]);
        end
    end

    // Valid bits and free count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            free_count <= CW'(DEPTH);
        end else begin
            valid_q    <= valid_d;
            free_count <= free_cnt_d;
        end
    end

    // Lowest-index free slot; scanning downward leaves the lowest hit last.
    always_comb begin
        free_slot_c = '0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (!valid_q[i-1]) begin
                free_slot_c = AW'(i - 1);
            end
        end
    end

    assign full_c     = &valid_q;
    assign rd_data_c  = pad_q[rd_slot];
    assign rd_valid_c = valid_q[rd_slot];

endmodule : otp_pad_store

// File: rtl/otp_pad_scheduler.sv
// Arbitrates encrypt/decrypt requests over the pad store and returns one
// registered response per accepted request.
module otp_pad_scheduler
    import otp_pkg::*;
#(
    parameter int unsigned W     = otp_pkg::W,
    parameter int unsigned DEPTH = otp_pkg::DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enc_valid,
    output logic          enc_ready,
    input  logic [W-1:0]  enc_data,
    input  logic          dec_valid,
    output logic          dec_ready,
    input  logic [W-1:0]  dec_data,
    input  logic [AW-1:0] dec_slot,
    input  logic [W-1:0]  prng_pad,
    output logic          prng_step,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic [AW-1:0] rsp_slot,
    output logic          rsp_is_dec,
    output logic          rsp_err,
    output logic [AW:0]   free_count
);

    state_e        state_q;
    state_e        state_d;
    gnt_e          last_grant_q;
    logic          grant_enc_c;
    logic          grant_dec_c;
    logic [W-1:0]  rd_data_c;
    logic          rd_valid_c;
    logic [AW-1:0] free_slot_c;
    logic          full_c;

    otp_pad_store #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (grant_enc_c),
        .wr_slot     (free_slot_c),
        .wr_data     (prng_pad),
        .inv_en      (grant_dec_c & rd_valid_c),
        .inv_slot    (dec_slot),
        .rd_slot     (dec_slot),
        .rd_data_c   (rd_data_c),
        .rd_valid_c  (rd_valid_c),
        .free_slot_c (free_slot_c),
        .full_c      (full_c),
        .free_count  (free_count)
    );

    // Next state, readies and round-robin grant; full_c equals (free_count == 0).
    always_comb begin
        state_d     = state_q;
        enc_ready   = 1'b0;
        dec_ready   = 1'b0;
        grant_enc_c = 1'b0;
        grant_dec_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                dec_ready = 1'b1;
                enc_ready = !full_c;
                if (enc_valid && enc_ready && dec_valid) begin
                    if (last_grant_q == GNT_DEC) begin
                        grant_enc_c = 1'b1;
                    end else begin
                        grant_dec_c = 1'b1;
                    end
                end else if (enc_valid && enc_ready) begin
                    grant_enc_c = 1'b1;
                end else if (dec_valid) begin
                    grant_dec_c = 1'b1;
                end
                if (grant_enc_c || grant_dec_c) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        prng_step = grant_enc_c;
    end

    // State and arbitration history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_DEC;
        end else begin
            state_q <= state_d;
            if (grant_enc_c) begin
                last_grant_q <= GNT_ENC;
            end else if (grant_dec_c) begin
                last_grant_q <= GNT_DEC;
            end
        end
    end

    // Response register: loaded at accept, held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_slot   <= '0;
            rsp_is_dec <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (grant_enc_c) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= enc_data ^ prng_pad;
            rsp_slot   <= free_slot_c;
            rsp_is_dec <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (grant_dec_c) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= rd_valid_c ? (dec_data ^ rd_data_c) : '0;
            rsp_slot   <= dec_slot;
            rsp_is_dec <= 1'b1;
            rsp_err    <= !rd_valid_c;
        end else if (state_q == S_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule : otp_pad_scheduler
